// File: rtl/line_stream_shell.sv
// Line streaming shell: splits cache lines into elements for a fixed-latency kernel and repacks the results into an output FIFO.
// Optional macro LINE_STREAM_SHELL_BYTE_SWAP_EN byte-reverses each kernel result before it is packed.
module line_stream_shell #(
  parameter int LINE_W     = 512,
  parameter int ELEM_W     = 64,
  parameter int KERNEL_LAT = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       num_lines,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [LINE_W-1:0] in_data,
  output logic              in_ready,
  output logic              k_valid,
  output logic [ELEM_W-1:0] k_data,
  input  logic [ELEM_W-1:0] k_result,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int EPL    = LINE_W / ELEM_W;
  localparam int IDX_W  = (EPL > 1) ? $clog2(EPL) : 1;
  localparam int CRED_W = $clog2(OUT_DEPTH * EPL + 1);
  localparam int AW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int PTR_W  = AW + 1;

  generate
    if ((LINE_W % ELEM_W) != 0 || KERNEL_LAT < 1 || OUT_DEPTH < 2 ||
        (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_params
      $error("line_stream_shell: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  function automatic logic [ELEM_W-1:0] byte_swap(input logic [ELEM_W-1:0] d);
    logic [ELEM_W-1:0] r;
    r = d;
    for (int i = 0; i < ELEM_W / 8; i++) begin
      r[i*8 +: 8] = d[ELEM_W-8-i*8 +: 8];
    end
    return r;
  endfunction

  state_t              state_r, state_nxt;
  logic                done_r, done_nxt, latch_job;
  logic [31:0]         num_r, acc_r, pop_cnt_r;
  logic [LINE_W-1:0]   unp_line_r;
  logic [IDX_W-1:0]    unp_idx_r;
  logic                unp_full_r;
  logic [ELEM_W-1:0]   k_data_r;
  logic [KERNEL_LAT-1:0] vld_sr_r;
  logic [LINE_W-1:0]   pack_line_r;
  logic [IDX_W-1:0]    pack_idx_r;
  logic [CRED_W-1:0]   credit_r;
  logic [LINE_W-1:0]   mem_r [OUT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;

  logic                issue, last_issue, in_ready_s, accept, capture, push, pop, out_valid_s;
  logic [ELEM_W-1:0]   elem, cap_elem;
  logic [LINE_W-1:0]   assembled;

  // job control: next state and the done pulse
  always_comb begin
    state_nxt = state_r;
    done_nxt  = 1'b0;
    latch_job = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (num_lines == 32'd0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = S_RUN;
            latch_job = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (acc_r == num_r) state_nxt = S_DRAIN;
        else                state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (pop_cnt_r == num_r) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath steering: issue, accept, element select, packing and FIFO handshakes
  always_comb begin
    issue       = unp_full_r && (credit_r != {CRED_W{1'b0}});
    last_issue  = issue && (unp_idx_r == IDX_W'(EPL - 1));
    in_ready_s  = (state_r == S_RUN) && (acc_r < num_r) && (!unp_full_r || last_issue);
    accept      = in_valid && in_ready_s;
    out_valid_s = (wr_ptr_r != rd_ptr_r);
    pop         = out_valid_s && out_ready;
    capture     = vld_sr_r[KERNEL_LAT-1];
    elem        = {ELEM_W{1'b0}};
    for (int i = 0; i < EPL; i++) begin
      if (unp_idx_r == IDX_W'(i)) elem = unp_line_r[i*ELEM_W +: ELEM_W];
    end
`ifdef LINE_STREAM_SHELL_BYTE_SWAP_EN
    cap_elem = byte_swap(k_result);
`else
    cap_elem = k_result;
`endif
    assembled = pack_line_r;
    for (int i = 0; i < EPL; i++) begin
      if (pack_idx_r == IDX_W'(i)) assembled[i*ELEM_W +: ELEM_W] = cap_elem;
    end
    push = capture && (pack_idx_r == IDX_W'(EPL - 1));
  end

  // state, job counters and done register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      done_r    <= 1'b0;
      num_r     <= 32'd0;
      acc_r     <= 32'd0;
      pop_cnt_r <= 32'd0;
    end else begin
      state_r <= state_nxt;
      done_r  <= done_nxt;
      if (latch_job) begin
        num_r     <= num_lines;
        acc_r     <= 32'd0;
        pop_cnt_r <= 32'd0;
      end else begin
        if (accept) acc_r     <= acc_r + 32'd1;
        if (pop)    pop_cnt_r <= pop_cnt_r + 32'd1;
      end
    end
  end

  // unpacker, kernel issue tracking and credit accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      unp_line_r <= {LINE_W{1'b0}};
      unp_idx_r  <= {IDX_W{1'b0}};
      unp_full_r <= 1'b0;
      k_data_r   <= {ELEM_W{1'b0}};
      vld_sr_r   <= {KERNEL_LAT{1'b0}};
      credit_r   <= CRED_W'(OUT_DEPTH * EPL);
    end else begin
      if (accept) begin
        unp_line_r <= in_data;
        unp_idx_r  <= {IDX_W{1'b0}};
        unp_full_r <= 1'b1;
      end else if (last_issue) begin
        unp_full_r <= 1'b0;
      end else if (issue) begin
        unp_idx_r <= unp_idx_r + IDX_W'(1);
      end
      if (issue) k_data_r <= elem;
      vld_sr_r[0] <= issue;
      for (int i = 1; i < KERNEL_LAT; i++) vld_sr_r[i] <= vld_sr_r[i-1];
      credit_r <= credit_r - CRED_W'(issue) + (pop ? CRED_W'(EPL) : {CRED_W{1'b0}});
    end
  end

  // packer and output FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      pack_line_r <= {LINE_W{1'b0}};
      pack_idx_r  <= {IDX_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
    end else begin
      if (capture) begin
        pack_line_r <= assembled;
        pack_idx_r  <= push ? {IDX_W{1'b0}} : pack_idx_r + IDX_W'(1);
      end
      if (push) begin
        mem_r[wr_ptr_r[AW-1:0]] <= assembled;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // outputs are forced quiet while reset is held, even before the first reset edge
  assign busy      = !reset && (state_r != S_IDLE);
  assign done      = !reset && done_r;
  assign in_ready  = !reset && in_ready_s;
  assign k_valid   = !reset && issue;
  assign k_data    = reset ? {ELEM_W{1'b0}} : (issue ? elem : k_data_r);
  assign out_valid = !reset && out_valid_s;
  assign out_data  = out_valid ? mem_r[rd_ptr_r[AW-1:0]] : {LINE_W{1'b0}};

endmodule
